// File: rtl/ps2_pkt_if.sv
// Byte-in / packet-out signal bundle for ps2_pkt_ctrl.
// The slave modport is the controller; the master modport is the receiver/consumer side.
interface ps2_pkt_if;
    logic        in_valid;
    logic [7:0]  in_byte;
    logic        pkt_valid;
    logic        pkt_ready;
    logic [23:0] pkt_data;
    logic [7:0]  drop_cnt;
    logic        sync_err;
    logic        busy;

    modport master (
        output in_valid, in_byte, pkt_ready,
        input  pkt_valid, pkt_data, drop_cnt, sync_err, busy
    );

    modport slave (
        input  in_valid, in_byte, pkt_ready,
        output pkt_valid, pkt_data, drop_cnt, sync_err, busy
    );
endinterface

// File: rtl/ps2_pkt_ctrl.sv
// PS/2 packet controller: assembles 3-byte mouse packets aligned on the bit-3
// sync marker and buffers them in a small FIFO with a valid/ready output.
// Optional feature macro: PS2_PKT_TIMEOUT_EN (inter-byte timeout abandons a
// stalled partial packet). Without it the assembler waits indefinitely.
module ps2_pkt_ctrl #(
    parameter int unsigned DEPTH          = 4,
    parameter int unsigned TIMEOUT_CYCLES = 50000,
    parameter int unsigned CNT_W          = 16
) (
    input  logic      clk,
    input  logic      reset,
    ps2_pkt_if.slave  bus
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        BYTE2 = 2'd1,
        BYTE3 = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [7:0]  b1, b1_nxt;
    logic [7:0]  b2, b2_nxt;
    logic        push, push_nxt;
    logic [23:0] push_data, push_data_nxt;
    logic        sync_err, sync_err_nxt;

`ifdef PS2_PKT_TIMEOUT_EN
    logic [CNT_W-1:0] tmo_cnt, tmo_cnt_nxt;
`endif

    logic [23:0] mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count;
    logic [7:0]    drop_cnt;
    logic          full, pop, wr_en;

    // Assembler state, latched bytes, registered push request and error pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= SYNC;
            b1        <= '0;
            b2        <= '0;
            push      <= 1'b0;
            push_data <= '0;
            sync_err  <= 1'b0;
`ifdef PS2_PKT_TIMEOUT_EN
            tmo_cnt   <= '0;
`endif
        end else begin
            state     <= state_nxt;
            b1        <= b1_nxt;
            b2        <= b2_nxt;
            push      <= push_nxt;
            push_data <= push_data_nxt;
            sync_err  <= sync_err_nxt;
`ifdef PS2_PKT_TIMEOUT_EN
            tmo_cnt   <= tmo_cnt_nxt;
`endif
        end
    end

    // Next-state logic: byte sequencing, sync check and (optionally) the idle timeout.
    always_comb begin
        state_nxt     = state;
        b1_nxt        = b1;
        b2_nxt        = b2;
        push_nxt      = 1'b0;
        push_data_nxt = push_data;
        sync_err_nxt  = 1'b0;
`ifdef PS2_PKT_TIMEOUT_EN
        tmo_cnt_nxt   = '0;
`endif
        case (state)
            SYNC: begin
                if (bus.in_valid) begin
                    if (bus.in_byte[3]) begin
                        b1_nxt    = bus.in_byte;
                        state_nxt = BYTE2;
                    end else begin
                        sync_err_nxt = 1'b1;
                    end
                end
            end
            BYTE2: begin
                if (bus.in_valid) begin
                    b2_nxt    = bus.in_byte;
                    state_nxt = BYTE3;
                end
            end
            BYTE3: begin
                if (bus.in_valid) begin
                    push_nxt      = 1'b1;
                    push_data_nxt = {b1, b2, bus.in_byte};
                    state_nxt     = SYNC;
                end
            end
            default: state_nxt = SYNC;
        endcase
`ifdef PS2_PKT_TIMEOUT_EN
        // Timeout fires on the idle edge that would bring the count to TIMEOUT_CYCLES.
        if (state != SYNC && !bus.in_valid) begin
            if (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                state_nxt    = SYNC;
                sync_err_nxt = 1'b1;
                tmo_cnt_nxt  = '0;
            end else begin
                tmo_cnt_nxt = tmo_cnt + 1'b1;
            end
        end
`endif
    end

    assign full  = (count == CW'(DEPTH));
    assign pop   = bus.pkt_valid && bus.pkt_ready;
    // A full FIFO still accepts a push when the head is popped on the same edge.
    assign wr_en = push && (!full || pop);

    // Packet storage; contents need no reset because occupancy gates visibility.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // FIFO pointers, occupancy and saturating drop counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            drop_cnt <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (wr_en && !pop) begin
                count <= count + 1'b1;
            end else if (!wr_en && pop) begin
                count <= count - 1'b1;
            end
            if (push && full && !pop && drop_cnt != '1) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
        end
    end

    assign bus.pkt_valid = (count != '0);
    assign bus.pkt_data  = bus.pkt_valid ? mem[rd_ptr] : '0;
    assign bus.drop_cnt  = drop_cnt;
    assign bus.sync_err  = sync_err;
    assign bus.busy      = (state != SYNC);

endmodule

// File: tb/tb_ps2_pkt_ctrl.sv
// Scoreboard bench for ps2_pkt_ctrl: a queue-level reference model predicts
// per-cycle status and accepted packets; a separate monitor compares them.
module tb_ps2_pkt_ctrl;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned TMO   = 10;

    logic clk = 1'b0;
    logic reset;

    ps2_pkt_if bus ();

    ps2_pkt_ctrl #(
        .DEPTH          (DEPTH),
        .TIMEOUT_CYCLES (TMO),
        .CNT_W          (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       flush;
        logic       sync_err;
        logic       busy;
        logic       valid;
        logic [7:0] drop;
    } exp_t;

    int checks = 0;
    int errors = 0;

    exp_t        cyc_q[$];
    logic [23:0] exp_pkt_q[$];

    // reference model state
    logic [7:0]  partial[$];
    logic [23:0] mfifo[$];
    logic        pend_v = 1'b0;
    logic [23:0] pend_d = '0;
    int          m_drop = 0;
`ifdef PS2_PKT_TIMEOUT_EN
    int          idle_run = 0;
`endif

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Drive one clock's inputs, advance the model across that edge, then step past it.
    task automatic cycle(input logic rst, input logic iv, input logic [7:0] ib, input logic rdy);
        exp_t e;
        logic err;
        reset         = rst;
        bus.in_valid  = iv;
        bus.in_byte   = ib;
        bus.pkt_ready = rdy;
        err = 1'b0;
        if (rst) begin
            partial.delete();
            mfifo.delete();
            pend_v = 1'b0;
            m_drop = 0;
`ifdef PS2_PKT_TIMEOUT_EN
            idle_run = 0;
`endif
        end else begin
            if (mfifo.size() > 0 && rdy) void'(mfifo.pop_front());
            if (pend_v) begin
                if (mfifo.size() < DEPTH) begin
                    mfifo.push_back(pend_d);
                    exp_pkt_q.push_back(pend_d);
                end else if (m_drop < 255) begin
                    m_drop++;
                end
            end
            pend_v = 1'b0;
            if (iv) begin
`ifdef PS2_PKT_TIMEOUT_EN
                idle_run = 0;
`endif
                if (partial.size() == 0) begin
                    if (ib[3]) partial.push_back(ib);
                    else err = 1'b1;
                end else begin
                    partial.push_back(ib);
                    if (partial.size() == 3) begin
                        pend_v = 1'b1;
                        pend_d = {partial[0], partial[1], partial[2]};
                        partial.delete();
                    end
                end
            end else if (partial.size() != 0) begin
`ifdef PS2_PKT_TIMEOUT_EN
                idle_run++;
                if (idle_run == TMO) begin
                    partial.delete();
                    idle_run = 0;
                    err = 1'b1;
                end
`endif
            end
        end
        e.flush    = rst;
        e.sync_err = err;
        e.busy     = (partial.size() != 0);
        e.valid    = (mfifo.size() != 0);
        e.drop     = 8'(m_drop);
        cyc_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input logic rdy);
        cycle(1'b0, 1'b1, b, rdy);
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 8'h00, rdy);
    endtask

    task automatic do_reset();
        cycle(1'b1, 1'b0, 8'h00, 1'b0);
        cycle(1'b1, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic send_pkt(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic rdy);
        send(a, rdy);
        send(b, rdy);
        send(c, rdy);
    endtask

    // Monitor: compare per-cycle status and every accepted packet at its handshake.
    initial begin
        exp_t e;
        logic [23:0] want;
        forever begin
            @(negedge clk);
            #2;
            if (cyc_q.size() != 0) begin
                e = cyc_q.pop_front();
                if (e.flush) begin
                    exp_pkt_q.delete();
                    check("reset_pkt_data", 32'(bus.pkt_data), 32'h0);
                end
                check("sync_err", 32'(bus.sync_err), 32'(e.sync_err));
                check("busy", 32'(bus.busy), 32'(e.busy));
                check("pkt_valid", 32'(bus.pkt_valid), 32'(e.valid));
                check("drop_cnt", 32'(bus.drop_cnt), 32'(e.drop));
            end
            if (bus.pkt_valid && bus.pkt_ready && !reset) begin
                if (exp_pkt_q.size() == 0) begin
                    check("unexpected_pkt", 32'(bus.pkt_data), 32'hFFFFFFFF);
                end else begin
                    want = exp_pkt_q.pop_front();
                    check("pkt_data", 32'(bus.pkt_data), 32'(want));
                end
            end
        end
    end

    // Stimulus: directed test-plan scenarios, saturation, then randomized traffic.
    initial begin
        logic [7:0] rb;
        logic       riv;
        int         pct;

        bus.in_valid  = 1'b0;
        bus.in_byte   = '0;
        bus.pkt_ready = 1'b0;
        reset         = 1'b1;
        do_reset();

        // aligned packet
        send_pkt(8'h08, 8'h12, 8'h34, 1'b1);
        idle(4, 1'b1);

        // resync: two discarded bytes then a packet
        send(8'h00, 1'b1);
        send(8'h01, 1'b1);
        send_pkt(8'h09, 8'hAA, 8'hBB, 1'b1);
        idle(4, 1'b1);

`ifdef PS2_PKT_TIMEOUT_EN
        // timeout abandons a stalled partial packet
        send(8'h08, 1'b1);
        send(8'h11, 1'b1);
        idle(10, 1'b1);
        check("tmo_busy", 32'(bus.busy), 32'h0);
        send_pkt(8'h18, 8'h22, 8'h33, 1'b1);
        idle(4, 1'b1);
`endif

        // overflow: six packets into a 4-deep FIFO with no consumer
        do_reset();
        for (int p = 0; p < 6; p++) send_pkt(8'h08, 8'(p), 8'(8'hA0 + p), 1'b0);
        idle(3, 1'b0);
        check("ovf_drop", 32'(bus.drop_cnt), 32'd2);
        check("ovf_valid", 32'(bus.pkt_valid), 32'd1);
        idle(8, 1'b1);

        // full FIFO with a pop on the same edge as the write
        do_reset();
        for (int p = 0; p < 4; p++) send_pkt(8'h0F, 8'(p), 8'h5A, 1'b0);
        idle(2, 1'b0);
        send_pkt(8'h0F, 8'h44, 8'h5A, 1'b0);
        idle(1, 1'b1);
        idle(2, 1'b0);
        check("fullpop_drop", 32'(bus.drop_cnt), 32'd0);
        idle(8, 1'b1);

        // mid-packet reset
        send(8'h08, 1'b1);
        send(8'h55, 1'b1);
        cycle(1'b1, 1'b0, 8'h00, 1'b1);
        check("rst_busy", 32'(bus.busy), 32'd0);
        send(8'h66, 1'b1);
        idle(4, 1'b1);

        // drop counter saturation
        do_reset();
        for (int p = 0; p < 262; p++) send_pkt(8'h08, 8'(p), 8'h01, 1'b0);
        idle(3, 1'b0);
        check("sat_drop", 32'(bus.drop_cnt), 32'd255);
        idle(8, 1'b1);

        // randomized traffic with varying byte density and consumer pace
        do_reset();
        pct = 90;
        for (int c = 0; c < 3000; c++) begin
            if (c % 60 == 0) begin
                case ($urandom_range(2))
                    0: pct = 95;
                    1: pct = 50;
                    default: pct = 6;
                endcase
            end
            rb = 8'($urandom);
            if ($urandom_range(3) != 0) rb[3] = 1'b1;
            riv = ($urandom_range(99) < pct);
            if ($urandom_range(399) == 0) cycle(1'b1, 1'b0, 8'h00, 1'b0);
            else cycle(1'b0, riv, rb, ($urandom_range(99) < 55));
        end

        idle(20, 1'b1);
        idle(2, 1'b1);
        check("drained", 32'(exp_pkt_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_pkt_ctrl.md
# ps2_pkt_ctrl

Packet controller between the PS/2 byte receiver and the mouse consumer logic. It sequences raw received bytes into aligned 3-byte movement packets, using the bit-3 sync marker of the first byte. It recovers alignment after stalled or partial packets and buffers complete packets in a small FIFO. Packets are delivered through a valid/ready handshake, so a slow consumer never stalls the receiver.

## Interface
Parameters:
- `DEPTH`, default 4: packet FIFO entries; must be a power of 2, minimum 2.
- `TIMEOUT_CYCLES`, default 50000: idle clocks mid-packet before the partial packet is abandoned.
- `CNT_W`, default 16: width of the timeout counter; must hold `TIMEOUT_CYCLES`.

Ports:
- `clk`  in  1: clock.
- `reset`  in  1: synchronous, active-high.
- `in_valid`  in  1: one-cycle strobe; `in_byte` is a new received byte.
- `in_byte`  in  8: received byte.
- `pkt_valid`  out  1: FIFO head holds a packet.
- `pkt_ready`  in  1: consumer accepts the head this cycle.
- `pkt_data`  out  24: head packet; [23:16] first byte, [15:8] second, [7:0] third.
- `drop_cnt`  out  8: saturating count of complete packets dropped because the FIFO was full.
- `sync_err`  out  1: one-cycle pulse on a discarded byte or an abandoned partial packet.
- `busy`  out  1: high while a packet is partially assembled (state not `SYNC`).

## Operation
Assembly FSM with states `SYNC`, `BYTE2`, `BYTE3`. Every transition is qualified by `in_valid`.
- **`SYNC`:**
  - `in_byte[3]`=1: latch the byte as byte 1 and go to `BYTE2`.
  - `in_byte[3]`=0: discard the byte, pulse `sync_err`, stay in `SYNC`.
- **`BYTE2`:** latch byte 2 and go to `BYTE3`. Bit 3 is not checked.
- **`BYTE3`:** latch byte 3, issue a push of {b1,b2,b3}, and go to `SYNC`.

Timeout (see Configuration):
- In `BYTE2` and `BYTE3`, a counter increments each cycle without `in_valid` and clears on `in_valid`.
- On reaching `TIMEOUT_CYCLES`: go to `SYNC`, discard the partial bytes, pulse `sync_err`.
- The counter clears on entry to `SYNC`.

FIFO:
- Circular buffer with read/write pointers and an occupancy count.
- Pop occurs when `pkt_valid && pkt_ready`.
- Push when not full: write at the tail.
- Push when full with a simultaneous pop: accepted. The pop frees the slot and the push writes it.
- Push when full without a pop: the packet is dropped and `drop_cnt` increments, saturating at 255.
- Pointers wrap modulo `DEPTH`.

Reset values:
- state `SYNC`
- FIFO empty, so `pkt_valid`=0
- `pkt_data`=0
- `drop_cnt`=0
- `sync_err`=0
- `busy`=0
- timeout counter 0

Reset mid-packet or mid-handshake discards all held bytes and packets.

## Timing
- Byte 3 is accepted at edge N. The packet is written at edge N+1, and `pkt_valid` is high in the cycle after N+1. Latency from byte-3 strobe to visible packet is 2 cycles.
- `pkt_data` is valid whenever `pkt_valid`=1 and holds stable until popped.
- After a pop, the next entry is presented in the following cycle.
- `pkt_valid` never drops without a pop, except on reset.
- `sync_err` is registered: high for the cycle after the offending edge.
- Back-to-back `in_valid` on consecutive cycles is supported at full rate.
- The FSM is never stalled by a full FIFO.

## Configuration
Macro `PS2_PKT_TIMEOUT_EN`:
- **Defined:** the inter-byte timeout is implemented as described.
- **Undefined:** no timeout counter; the FSM waits indefinitely in `BYTE2`/`BYTE3`. `TIMEOUT_CYCLES` and `CNT_W` are ignored, and `sync_err` fires only for discarded bytes in `SYNC`.

## Test plan
1. **Aligned packet.** Bytes 0x08, 0x12, 0x34 with `pkt_ready`=1 → `pkt_data`=0x081234 with a `pkt_valid` pulse 2 cycles after byte 3; `sync_err` stays 0.
2. **Resync.** Bytes 0x00, 0x01, 0x09, 0xAA, 0xBB → two `sync_err` pulses, then one packet 0x09AABB.
3. **Timeout.** `TIMEOUT_CYCLES`=10; bytes 0x08, 0x11, then 10 idle cycles, then 0x18, 0x22, 0x33 → `sync_err` pulse and `busy` low after the idle gap; the only packet delivered is 0x182233.
4. **Overflow.** `DEPTH`=4 with `pkt_ready`=0; feed 6 valid packets → `pkt_valid`=1, `drop_cnt`=2; draining yields the first 4 packets in order.
5. **Full plus simultaneous pop.** FIFO full; pop on the same cycle as a push → no drop, `drop_cnt` unchanged, order preserved.
6. **Mid-packet reset.** Bytes 0x08, 0x55, then reset for 1 cycle, then 0x66 → no packet delivered, `busy`=0, `sync_err` pulse for 0x66 (bit 3 = 0).
